// File: rtl/sr_ff_pkg.sv
// Shared encodings for the sr_ff_bank flag register: mode values and SR conflict rules.

package sr_ff_pkg;

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_D  = 2'b10,
    MODE_T  = 2'b11
  } mode_t;

  localparam int unsigned PRIO_SET  = 0;
  localparam int unsigned PRIO_RST  = 1;
  localparam int unsigned PRIO_HOLD = 2;

endpackage

// File: rtl/sr_ff_cell.sv
// One storage bit of sr_ff_bank: mode-dependent next-state function plus q/qb/conflict registers.

module sr_ff_cell
  import sr_ff_pkg::*;
#(
  parameter logic        RST_BIT = 1'b0,
  parameter int unsigned SR_PRIO = PRIO_SET
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] mode_i,
  input  logic       ce_i,
  input  logic       a_i,
  input  logic       b_i,
  output logic       q_o,
  output logic       qb_o,
  output logic       conflict_o,
  output logic       q_d_o,
  output logic       conflict_d_o
);

  logic q_d, q_q;
  logic qb_q;
  logic conflict_d, conflict_q;

  always_comb begin
    q_d        = q_q;
    conflict_d = 1'b0;
    if (ce_i) begin
      case (mode_i)
        MODE_SR: begin
          case ({a_i, b_i})
            2'b10: q_d = 1'b1;
            2'b01: q_d = 1'b0;
            2'b11: begin
              conflict_d = 1'b1;
              if (SR_PRIO == PRIO_SET) begin
                q_d = 1'b1;
              end else if (SR_PRIO == PRIO_RST) begin
                q_d = 1'b0;
              end
            end
            default: q_d = q_q;
          endcase
        end
        MODE_JK: begin
          case ({a_i, b_i})
            2'b10:   q_d = 1'b1;
            2'b01:   q_d = 1'b0;
            2'b11:   q_d = ~q_q;
            default: q_d = q_q;
          endcase
        end
        MODE_D:  q_d = a_i;
        MODE_T:  q_d = a_i ? ~q_q : q_q;
        default: q_d = q_q;
      endcase
    end
  end

  // qb is its own flop loaded with ~q_d so it is never equal to q, even on conflicts.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q        <= RST_BIT;
      qb_q       <= ~RST_BIT;
      conflict_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      qb_q       <= ~q_d;
      conflict_q <= conflict_d;
    end
  end

  assign q_o          = q_q;
  assign qb_o         = qb_q;
  assign conflict_o   = conflict_q;
  assign q_d_o        = q_d;
  assign conflict_d_o = conflict_d;

endmodule

// File: rtl/sr_ff_bank.sv
// WIDTH-channel SR/JK/D/T flag register with mode register, conflict pulses and sticky err.
// Define SR_FF_BANK_CHG_CNT_EN to add the saturating chg_cnt output.

module sr_ff_bank
  import sr_ff_pkg::*;
#(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] RST_VAL  = '0,
  parameter logic [1:0]       RST_MODE = 2'b00,
  parameter int unsigned      SR_PRIO  = PRIO_SET,
  parameter int unsigned      CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode_ld,
  input  logic [1:0]       mode_in,
  input  logic [WIDTH-1:0] ce,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [1:0]       mode,
  output logic [WIDTH-1:0] conflict,
  output logic             err,
  input  logic             err_clr
`ifdef SR_FF_BANK_CHG_CNT_EN
  ,
  output logic [CNT_W-1:0] chg_cnt
`endif
);

  logic [1:0]       mode_d, mode_q;
  logic             err_d, err_q;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] conflict_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_ff_cell #(
      .RST_BIT (RST_VAL[i]),
      .SR_PRIO (SR_PRIO)
    ) u_cell (
      .clk_i        (clk),
      .rst_i        (rst),
      .mode_i       (mode_q),
      .ce_i         (ce[i]),
      .a_i          (a[i]),
      .b_i          (b[i]),
      .q_o          (q[i]),
      .qb_o         (qb[i]),
      .conflict_o   (conflict[i]),
      .q_d_o        (q_next[i]),
      .conflict_d_o (conflict_next[i])
    );
  end

  // Set beats clear when a conflict and err_clr land in the same cycle.
  always_comb begin
    mode_d = mode_ld ? mode_in : mode_q;
    err_d  = err_q;
    if (|conflict_next) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= RST_MODE;
      err_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      err_q  <= err_d;
    end
  end

  assign mode = mode_q;
  assign err  = err_q;

`ifdef SR_FF_BANK_CHG_CNT_EN
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             changed;

  assign changed = |(q_next ^ q);

  always_comb begin
    cnt_d = cnt_q;
    if (err_clr) begin
      cnt_d = changed ? CNT_W'(1) : '0;
    end else if (changed && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign chg_cnt = cnt_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_sr_ff_bank.sv
// Self-checking bench for sr_ff_bank: three instances (SR_PRIO 0/1/2) against a behavioural model.

module tb_sr_ff_bank;

  localparam int unsigned W = 8;
  localparam logic [7:0]  RV = 8'hA5;
`ifdef SR_FF_BANK_CHG_CNT_EN
  localparam int unsigned CntW = 2;
`else
  localparam int unsigned CntW = 16;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mode_ld = 1'b0;
  logic       err_clr = 1'b0;
  logic [1:0] mode_in = 2'b00;
  logic [7:0] ce = '0, a = '0, b = '0;

  logic [7:0] dq[3], dqb[3], dconf[3];
  logic [1:0] dmode[3];
  logic       derr[3];
`ifdef SR_FF_BANK_CHG_CNT_EN
  logic [CntW-1:0] dcnt[3];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sr_ff_bank #(
      .WIDTH    (W),
      .RST_VAL  (RV),
      .RST_MODE (2'b00),
      .SR_PRIO  (g),
      .CNT_W    (CntW)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .mode_ld  (mode_ld),
      .mode_in  (mode_in),
      .ce       (ce),
      .a        (a),
      .b        (b),
      .q        (dq[g]),
      .qb       (dqb[g]),
      .mode     (dmode[g]),
      .conflict (dconf[g]),
      .err      (derr[g]),
      .err_clr  (err_clr)
`ifdef SR_FF_BANK_CHG_CNT_EN
      ,
      .chg_cnt  (dcnt[g])
`endif
    );
  end

  // Reference model state
  logic [7:0]  mq[3];
  logic [1:0]  mmode;
  logic [7:0]  mconf;
  logic        merr;
  int unsigned mcnt[3];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic next_bit(input int prio, input logic [1:0] md, input logic c,
                                    input logic s, input logic r, input logic cur);
    if (!c) return cur;
    case (md)
      2'd0: begin
        if (s && r) return (prio == 0) ? 1'b1 : (prio == 1) ? 1'b0 : cur;
        if (s) return 1'b1;
        if (r) return 1'b0;
        return cur;
      end
      2'd1: begin
        if (s && r) return ~cur;
        if (s) return 1'b1;
        if (r) return 1'b0;
        return cur;
      end
      2'd2:    return s;
      default: return s ? ~cur : cur;
    endcase
  endfunction

  task automatic compare_all();
    logic [7:0] nqb;
    for (int p = 0; p < 3; p++) begin
      nqb = ~mq[p];
      check($sformatf("q[%0d]", p), 64'(dq[p]), 64'(mq[p]));
      check($sformatf("qb[%0d]", p), 64'(dqb[p]), 64'(nqb));
      check($sformatf("conflict[%0d]", p), 64'(dconf[p]), 64'(mconf));
      check($sformatf("err[%0d]", p), 64'(derr[p]), 64'(merr));
      check($sformatf("mode[%0d]", p), 64'(dmode[p]), 64'(mmode));
`ifdef SR_FF_BANK_CHG_CNT_EN
      check($sformatf("chg_cnt[%0d]", p), 64'(dcnt[p]), 64'(mcnt[p]));
`endif
    end
  endtask

  task automatic set_in(input logic ld, input logic [1:0] mi, input logic [7:0] c,
                        input logic [7:0] sa, input logic [7:0] sb, input logic clr);
    mode_ld = ld;
    mode_in = mi;
    ce      = c;
    a       = sa;
    b       = sb;
    err_clr = clr;
  endtask

  // One clock edge: predict from the pre-edge inputs, then check #1 after the edge.
  task automatic step();
    logic [7:0]  nq[3];
    logic [7:0]  nconf;
    int unsigned maxc;
    maxc  = (32'd1 << CntW) - 1;
    nconf = (mmode == 2'd0) ? (ce & a & b) : 8'h00;
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 8; i++)
        nq[p][i] = next_bit(p, mmode, ce[i], a[i], b[i], mq[p][i]);
    @(posedge clk);
    #1;
    if (nconf != 0) merr = 1'b1;
    else if (err_clr) merr = 1'b0;
    for (int p = 0; p < 3; p++) begin
      if (err_clr) mcnt[p] = (nq[p] != mq[p]) ? 1 : 0;
      else if ((nq[p] != mq[p]) && (mcnt[p] < maxc)) mcnt[p]++;
      mq[p] = nq[p];
    end
    mconf = nconf;
    if (mode_ld) mmode = mode_in;
    compare_all();
  endtask

  // Assert rst mid-cycle and check the outputs before any clock edge.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    for (int p = 0; p < 3; p++) begin
      mq[p]   = RV;
      mcnt[p] = 0;
    end
    mmode = 2'b00;
    mconf = 8'h00;
    merr  = 1'b0;
    check("rst_q_const", 64'(dq[0]), 64'h A5);
    check("rst_qb_const", 64'(dqb[0]), 64'h5A);
    check("rst_mode_const", 64'(dmode[0]), 64'h0);
    compare_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();

    // SR set/clear/hold
    set_in(1'b0, 2'b00, 8'hFF, 8'h0F, 8'hF0, 1'b0);
    step();
    check("sr_set_q", 64'(dq[0]), 64'h0F);
    check("sr_set_qb", 64'(dqb[0]), 64'hF0);
    set_in(1'b0, 2'b00, 8'hFF, 8'h00, 8'h00, 1'b0);
    step();
    check("sr_hold_q", 64'(dq[0]), 64'h0F);
    set_in(1'b0, 2'b00, 8'hFF, 8'h00, 8'hFF, 1'b0);
    step();

    // SR conflict under each priority
    set_in(1'b0, 2'b00, 8'h01, 8'h01, 8'h01, 1'b0);
    step();
    check("prio_set_q", 64'(dq[0]), 64'h01);
    check("prio_rst_q", 64'(dq[1]), 64'h00);
    check("prio_hold_q", 64'(dq[2]), 64'h00);
    check("conflict_pulse", 64'(dconf[0]), 64'h01);
    check("err_set", 64'(derr[0]), 64'h1);
    set_in(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0);
    step();
    check("conflict_gone", 64'(dconf[0]), 64'h00);
    check("err_sticky", 64'(derr[0]), 64'h1);
    set_in(1'b0, 2'b00, 8'h01, 8'h01, 8'h01, 1'b1);
    step();
    check("err_set_beats_clr", 64'(derr[1]), 64'h1);
    set_in(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 1'b1);
    step();
    check("err_cleared", 64'(derr[1]), 64'h0);

    // JK load in the same cycle as SR activity, then toggles
    set_in(1'b0, 2'b00, 8'hFF, 8'h00, 8'hFF, 1'b0);
    step();
    set_in(1'b1, 2'b01, 8'hFF, 8'hFF, 8'hFF, 1'b0);
    step();
    check("ld_edge_sr_q", 64'(dq[1]), 64'h00);
    check("ld_edge_conflict", 64'(dconf[1]), 64'hFF);
    check("mode_jk", 64'(dmode[1]), 64'h1);
    set_in(1'b0, 2'b01, 8'hFF, 8'hFF, 8'hFF, 1'b0);
    step();
    check("jk_toggle1", 64'(dq[1]), 64'hFF);
    step();
    check("jk_toggle2", 64'(dq[1]), 64'h00);

    // T mode
    set_in(1'b1, 2'b11, 8'h00, 8'h00, 8'h00, 1'b0);
    step();
    set_in(1'b0, 2'b11, 8'hFF, 8'h55, 8'h00, 1'b0);
    step();
    check("t_toggle1", 64'(dq[1]), 64'h55);
    step();
    check("t_toggle2", 64'(dq[1]), 64'h00);

    // D mode with partial ce
    set_in(1'b1, 2'b10, 8'h00, 8'h00, 8'h00, 1'b0);
    step();
    set_in(1'b0, 2'b10, 8'hFF, 8'h00, 8'h00, 1'b0);
    step();
    set_in(1'b0, 2'b10, 8'h0F, 8'hFF, 8'hFF, 1'b0);
    step();
    check("d_partial_ce", 64'(dq[2]), 64'h0F);

`ifdef SR_FF_BANK_CHG_CNT_EN
    do_reset();
    set_in(1'b1, 2'b11, 8'h00, 8'h00, 8'h00, 1'b0);
    step();
    set_in(1'b0, 2'b11, 8'h01, 8'h01, 8'h00, 1'b0);
    step();
    check("cnt_1", 64'(dcnt[0]), 64'd1);
    step();
    check("cnt_2", 64'(dcnt[0]), 64'd2);
    step();
    check("cnt_3", 64'(dcnt[0]), 64'd3);
    step();
    check("cnt_sat", 64'(dcnt[0]), 64'd3);
    set_in(1'b0, 2'b11, 8'h01, 8'h01, 8'h00, 1'b1);
    step();
    check("cnt_clr_chg", 64'(dcnt[0]), 64'd1);
`endif

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
      end
      set_in(($urandom_range(0, 7) == 0), 2'($urandom), 8'($urandom), 8'($urandom),
             8'($urandom), ($urandom_range(0, 7) == 0));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
